// File: rtl/qs_pkg.sv
// qs_pkg: shared types for the quicksort accelerator bank lifecycle.
// Holds the bank status/state table types, datapath widths, the egress FSM
// state enum, the skid entry layout and the round-robin bank pointer helper.
package qs_pkg;

  localparam int unsigned N       = 16;  // maximum words per bank
  localparam int unsigned W       = 32;  // word width
  localparam int unsigned BANKS_N = 4;   // number of banks

  localparam int unsigned AddrW = $clog2(N);
  localparam int unsigned BankW = $clog2(BANKS_N);

  typedef logic [BankW-1:0] bank_id_t;
  typedef logic [AddrW-1:0] addr_t;
  typedef logic [W-1:0]     w_t;

  typedef enum logic [2:0] {
    BANK_IDLE      = 3'd0,
    BANK_LOADING   = 3'd1,
    BANK_READY     = 3'd2,
    BANK_SORTING   = 3'd3,
    BANK_SORTED    = 3'd4,
    BANK_UNLOADING = 3'd5
  } bank_status_t;

  // One bank table entry: n is the last valid index (inclusive).
  typedef struct packed {
    bank_status_t status;
    addr_t        n;
    logic         err;
  } bank_state_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLAIM   = 3'd1,
    STREAM  = 3'd2,
    DRAIN   = 3'd3,
    RELEASE = 3'd4
  } egress_state_t;

  typedef struct packed {
    w_t   w;
    logic last;
    logic err;
  } skid_entry_t;

  // Wraps on the bank count rather than relying on bit-width overflow, so a
  // non-power-of-two BANKS_N still visits only real banks.
  function automatic bank_id_t bank_id_inc(input bank_id_t id);
    if (id == bank_id_t'(BANKS_N - 1)) begin
      return '0;
    end
    return id + bank_id_t'(1);
  endfunction

endpackage

// File: rtl/qs_skid2.sv
// qs_skid2: 2-entry FIFO holding output beats {w, last, err}.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   push         write push_data this cycle (must not be asserted when full)
//   push_data    entry to store
//   pop          consume the head entry (must not be asserted when empty)
//   head         oldest entry, stable until popped
//   count        current occupancy 0..2, feeds the read-credit computation
module qs_skid2
  import qs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  skid_entry_t push_data,
  input  logic        pop,
  output skid_entry_t head,
  output logic [1:0]  count
);

  skid_entry_t mem_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (count_q != 2'd2));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    pop |-> (count_q != 2'd0));

endmodule

// File: rtl/qs_egress.sv
// qs_egress: unload engine for the quicksort accelerator.
// Visits banks strictly round-robin, waits for the current bank to be
// SORTED, claims it (UNLOADING), streams its words through a 2-entry skid
// buffer that absorbs the 1-cycle RAM latency, then returns it to IDLE.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   bank_state_r                    bank state table (status, n, err per bank)
//   bank_upd_vld/_id/_status        one-cycle bank status update strobe
//   rd_en, rd_bank, rd_addr         bank RAM read request
//   rd_data                         read data, valid the cycle after rd_en
//   out_vld, out_w, out_last,
//   out_err, out_rdy                valid/ready output beat stream
module qs_egress
  import qs_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  bank_state_t [BANKS_N-1:0]     bank_state_r,
  output logic                          bank_upd_vld,
  output bank_id_t                      bank_upd_id,
  output bank_status_t                  bank_upd_status,
  output logic                          rd_en,
  output bank_id_t                      rd_bank,
  output addr_t                         rd_addr,
  input  w_t                            rd_data,
  output logic                          out_vld,
  output w_t                            out_w,
  output logic                          out_last,
  output logic                          out_err,
  input  logic                          out_rdy
);

  egress_state_t state_q, state_d;
  bank_id_t      ptr_q, ptr_d;
  addr_t         n_q, n_d;
  logic          err_q, err_d;
  addr_t         addr_q, addr_d;
  logic          rd_pend_q;  // read issued last cycle, data on rd_data now
  logic          rd_last_q;  // that read was for address n

  logic        err_push;
  logic        skid_push;
  skid_entry_t skid_in;
  skid_entry_t skid_head;
  logic [1:0]  skid_count;
  logic        hs;
  logic [2:0]  usage;
  logic        credit_ok;

  assign out_vld = (skid_count != 2'd0);
  assign hs      = out_vld & out_rdy;

  // A beat leaving this cycle frees its slot before any read issued now can
  // return data, so it is credited back immediately to avoid bubbles.
  assign usage     = 3'(skid_count) + 3'(rd_pend_q) - 3'(hs);
  assign credit_ok = (usage < 3'd2);

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    n_d             = n_q;
    err_d           = err_q;
    addr_d          = addr_q;
    bank_upd_vld    = 1'b0;
    bank_upd_status = BANK_IDLE;
    rd_en           = 1'b0;
    err_push        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bank_state_r[ptr_q].status == BANK_SORTED) begin
          state_d = CLAIM;
        end
      end
      CLAIM: begin
        bank_upd_vld    = 1'b1;
        bank_upd_status = BANK_UNLOADING;
        n_d             = bank_state_r[ptr_q].n;
        err_d           = bank_state_r[ptr_q].err;
        addr_d          = '0;
        state_d         = STREAM;
      end
      STREAM: begin
        if (err_q) begin
          // Error bank: emit one marker beat instead of reading the RAM.
          err_push = 1'b1;
          state_d  = DRAIN;
        end else if (credit_ok) begin
          rd_en = 1'b1;
          if (addr_q == n_q) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + addr_t'(1);
          end
        end
      end
      DRAIN: begin
        if (hs && skid_head.last) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        bank_upd_vld    = 1'b1;
        bank_upd_status = BANK_IDLE;
        ptr_d           = bank_id_inc(ptr_q);
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      n_q       <= '0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      n_q       <= n_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      rd_pend_q <= rd_en;
      rd_last_q <= rd_en && (addr_q == n_q);
    end
  end

  assign skid_push = rd_pend_q | err_push;

  always_comb begin
    if (rd_pend_q) begin
      skid_in = '{w: rd_data, last: rd_last_q, err: 1'b0};
    end else begin
      skid_in = '{w: '0, last: 1'b1, err: 1'b1};
    end
  end

  qs_skid2 u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (skid_push),
    .push_data (skid_in),
    .pop       (hs),
    .head      (skid_head),
    .count     (skid_count)
  );

  // Outputs are forced to zero whenever they carry no meaning.
  assign out_w       = out_vld ? skid_head.w : '0;
  assign out_last    = out_vld & skid_head.last;
  assign out_err     = out_vld & skid_head.err;
  assign rd_bank     = rd_en ? ptr_q : '0;
  assign rd_addr     = rd_en ? addr_q : '0;
  assign bank_upd_id = bank_upd_vld ? ptr_q : '0;

  a_upd_spaced: assert property (@(posedge clk) disable iff (!rst_n)
    bank_upd_vld |=> !bank_upd_vld);
  a_push_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(rd_pend_q && err_push));

endmodule

// File: tb/tb_qs_egress.sv
module tb_qs_egress;
  import qs_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  bank_state_t [BANKS_N-1:0] tbl;
  logic                      bank_upd_vld;
  bank_id_t                  bank_upd_id;
  bank_status_t              bank_upd_status;
  logic                      rd_en;
  bank_id_t                  rd_bank;
  addr_t                     rd_addr;
  w_t                        rd_data = '0;
  logic                      out_vld;
  w_t                        out_w;
  logic                      out_last;
  logic                      out_err;
  logic                      out_rdy;

  typedef struct {
    w_t   w;
    logic last;
    logic err;
    int   cyc;
  } beat_t;

  typedef struct {
    bank_id_t     id;
    bank_status_t st;
    int           cyc;
  } upd_t;

  w_t          mem [BANKS_N][N];
  beat_t       bq[$];
  upd_t        sq[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          rd_total = 0;
  int          rdy_mode = 0;
  logic        set_req = 1'b0;
  bank_id_t    set_id = '0;
  bank_state_t set_val = '0;

  qs_egress dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bank_state_r    (tbl),
    .bank_upd_vld    (bank_upd_vld),
    .bank_upd_id     (bank_upd_id),
    .bank_upd_status (bank_upd_status),
    .rd_en           (rd_en),
    .rd_bank         (rd_bank),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .out_vld         (out_vld),
    .out_w           (out_w),
    .out_last        (out_last),
    .out_err         (out_err),
    .out_rdy         (out_rdy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: one-cycle read latency.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_bank][rd_addr];

  // Bank table model: stimulus writes plus DUT status updates.
  always @(posedge clk) begin
    if (!rst_n) begin
      tbl <= '0;
    end else begin
      if (set_req) tbl[set_id] <= set_val;
      if (bank_upd_vld) tbl[bank_upd_id].status <= bank_upd_status;
    end
  end

  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) out_rdy = 1'b1;
      else out_rdy = ~out_rdy;
    end
  end

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  bit       stall_q = 1'b0;
  w_t       hold_w;
  logic     hold_last, hold_err;
  int       issued = 0, accepted = 0;
  bank_id_t cur_bank = '0;
  beat_t    eb;
  upd_t     eu;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q  = 1'b0;
      issued   = 0;
      accepted = 0;
    end else begin
      if (bank_upd_vld) begin
        chk("upd_expected", sq.size() != 0, sq.size(), 1);
        if (sq.size() != 0) begin
          eu = sq.pop_front();
          chk("upd_id", bank_upd_id == eu.id, bank_upd_id, eu.id);
          chk("upd_status", bank_upd_status == eu.st, bank_upd_status, eu.st);
          if (eu.cyc >= 0) chk("upd_cycle", cyc == eu.cyc, cyc, eu.cyc);
        end
        if (bank_upd_status == BANK_UNLOADING) cur_bank = bank_upd_id;
      end
      if (stall_q) begin
        chk("stall_hold", out_vld && out_w == hold_w && out_last == hold_last &&
            out_err == hold_err, {out_vld, out_last, out_err}, {1'b1, hold_last, hold_err});
      end
      if (rd_en) begin
        rd_total++;
        chk("rd_bank", rd_bank == cur_bank, rd_bank, cur_bank);
        chk("outstanding", (issued - accepted - int'(out_vld && out_rdy)) <= 1,
            issued - accepted + 1, 2);
      end
      if (out_vld && out_rdy) begin
        chk("beat_expected", bq.size() != 0, bq.size(), 1);
        if (bq.size() != 0) begin
          eb = bq.pop_front();
          chk("beat_w", out_w == eb.w, out_w, eb.w);
          chk("beat_last", out_last == eb.last, out_last, eb.last);
          chk("beat_err", out_err == eb.err, out_err, eb.err);
          if (eb.cyc >= 0) chk("beat_cycle", cyc == eb.cyc, cyc, eb.cyc);
        end
      end
      stall_q   = out_vld && !out_rdy;
      hold_w    = out_w;
      hold_last = out_last;
      hold_err  = out_err;
      issued    += int'(rd_en);
      accepted  += int'(out_vld && out_rdy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bank(input bank_id_t id, input bank_status_t st, input int n,
                          input logic e);
    set_req = 1'b1;
    set_id  = id;
    set_val = '{status: st, n: addr_t'(n), err: e};
    tick();
    set_req = 1'b0;
  endtask

  task automatic fill(input int b, input int base);
    for (int a = 0; a < N; a++) mem[b][a] = w_t'(base + a * 7);
  endtask

  task automatic push_upd(input int id, input bank_status_t st, input int c);
    sq.push_back('{id: bank_id_t'(id), st: st, cyc: c});
  endtask

  task automatic push_beat(input w_t w, input logic l, input logic e, input int c);
    bq.push_back('{w: w, last: l, err: e, cyc: c});
  endtask

  task automatic exp_vector(input int b, input int n);
    push_upd(b, BANK_UNLOADING, -1);
    for (int a = 0; a <= n; a++) push_beat(mem[b][a], a == n, 1'b0, -1);
    push_upd(b, BANK_IDLE, -1);
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while ((bq.size() != 0 || sq.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    chk(name, bq.size() == 0 && sq.size() == 0, bq.size() + sq.size(), 0);
    bq.delete();
    sq.delete();
    repeat (2) tick();
  endtask

  task automatic do_reset(input int mode);
    rst_n = 1'b0;
    rdy_mode = mode;
    repeat (2) tick();
    bq.delete();
    sq.delete();
    rst_n = 1'b1;
    tick();
  endtask

  int t0;
  int rd0;

  initial begin
    for (int b = 0; b < BANKS_N; b++) fill(b, 32'h100 * (b + 1));

    // Reset state
    do_reset(0);
    chk("rst_out_vld", out_vld == 1'b0, out_vld, 0);
    chk("rst_rd_en", rd_en == 1'b0, rd_en, 0);
    chk("rst_upd_vld", bank_upd_vld == 1'b0, bank_upd_vld, 0);
    chk("rst_out_w", out_w == '0, out_w, 0);

    // 1: bank 0, n=3, data 10..13, cycle-exact timing
    for (int a = 0; a < 4; a++) mem[0][a] = w_t'(10 + a);
    set_bank(0, BANK_SORTED, 3, 1'b0);
    t0 = cyc;
    push_upd(0, BANK_UNLOADING, t0 + 1);
    push_beat(32'd10, 1'b0, 1'b0, t0 + 4);
    push_beat(32'd11, 1'b0, 1'b0, t0 + 5);
    push_beat(32'd12, 1'b0, 1'b0, t0 + 6);
    push_beat(32'd13, 1'b1, 1'b0, t0 + 7);
    push_upd(0, BANK_IDLE, t0 + 8);
    wait_done(40, "t1_done");

    // 2: same vector under 1010 backpressure
    do_reset(1);
    rd0 = rd_total;
    set_bank(0, BANK_SORTED, 3, 1'b0);
    push_upd(0, BANK_UNLOADING, -1);
    push_beat(32'd10, 1'b0, 1'b0, -1);
    push_beat(32'd11, 1'b0, 1'b0, -1);
    push_beat(32'd12, 1'b0, 1'b0, -1);
    push_beat(32'd13, 1'b1, 1'b0, -1);
    push_upd(0, BANK_IDLE, -1);
    wait_done(60, "t2_done");
    chk("t2_reads", rd_total - rd0 == 4, rd_total - rd0, 4);

    // 3: bank 1 sorted while bank 0 only READY -> no claim until bank 0 done
    do_reset(0);
    fill(0, 32'h500);
    rd0 = rd_total;
    set_bank(1, BANK_SORTED, 2, 1'b0);
    set_bank(0, BANK_READY, 1, 1'b0);
    repeat (10) tick();
    chk("t3_no_reads", rd_total == rd0, rd_total - rd0, 0);
    chk("t3_no_upd", sq.size() == 0 && bank_upd_vld == 1'b0, bank_upd_vld, 0);
    exp_vector(0, 1);
    exp_vector(1, 2);
    set_bank(0, BANK_SORTED, 1, 1'b0);
    wait_done(80, "t3_done");

    // 4: error bank -> single {0,last,err} beat, no reads
    do_reset(0);
    rd0 = rd_total;
    push_upd(0, BANK_UNLOADING, -1);
    push_beat('0, 1'b1, 1'b1, -1);
    push_upd(0, BANK_IDLE, -1);
    set_bank(0, BANK_SORTED, 5, 1'b1);
    wait_done(40, "t4_done");
    chk("t4_no_reads", rd_total == rd0, rd_total - rd0, 0);

    // 5: four banks back to back, fifth claim wraps to bank 0
    do_reset(0);
    for (int b = 0; b < BANKS_N; b++) exp_vector(b, 1);
    for (int b = 0; b < BANKS_N; b++) set_bank(bank_id_t'(b), BANK_SORTED, 1, 1'b0);
    wait_done(120, "t5_four");
    fill(0, 32'h900);
    exp_vector(0, 0);
    set_bank(0, BANK_SORTED, 0, 1'b0);
    wait_done(40, "t5_wrap");

    // 6: reset at word 5 of a 16-word vector on bank 1
    do_reset(0);
    fill(1, 32'hA00);
    exp_vector(0, 0);
    set_bank(0, BANK_SORTED, 0, 1'b0);
    wait_done(40, "t6_pre");
    set_bank(1, BANK_SORTED, 15, 1'b0);
    t0 = cyc;
    push_upd(1, BANK_UNLOADING, t0 + 1);
    for (int a = 0; a < 5; a++) push_beat(mem[1][a], 1'b0, 1'b0, t0 + 4 + a);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    chk("t6_out_vld", out_vld == 1'b0, out_vld, 0);
    chk("t6_rd_en", rd_en == 1'b0, rd_en, 0);
    chk("t6_upd_vld", bank_upd_vld == 1'b0, bank_upd_vld, 0);
    chk("t6_out_w", out_w == '0, out_w, 0);
    chk("t6_out_last", out_last == 1'b0, out_last, 0);
    chk("t6_consumed", bq.size() == 0 && sq.size() == 0, bq.size() + sq.size(), 0);
    rst_n = 1'b1;
    tick();
    fill(0, 32'hB00);
    exp_vector(0, 0);
    set_bank(0, BANK_SORTED, 0, 1'b0);
    wait_done(40, "t6_ptr_zero");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
